inport_feeder: RTL and testbench

INPORT_FEEDER -- requirements
Module: inport_feeder

---
 rtl/inport_feeder.sv | 119 +++++++++++
 tb/tb_inport_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inport_feeder.sv
// inport_feeder: two-entry FIFO that feeds device words into a CPU input-port
// register, one strobe per word, waiting for the CPU to read before the next.
`default_nettype none

module inport_feeder #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] dev_data,
    input  logic        dev_valid,
    output logic        dev_ready,
    input  logic        InPortout,
    output logic [31:0] device_data,
    output logic        Input_port_strobe,
    output logic        port_full,
    output logic [1:0]  fifo_count,
    output logic [7:0]  delivered_count
);

    localparam int         PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] FULL_LEVEL = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               inport_prev;
    logic               inport_rise;
    logic               push;
    logic               pop;

    assign dev_ready   = (fifo_count < FULL_LEVEL);
    assign push        = dev_valid && dev_ready;
    assign inport_rise = InPortout && !inport_prev;

    // Only an empty port pulls from the FIFO; a pop always starts a LOAD.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        port_full  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != 2'd0) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                port_full  = 1'b1;
                state_next = HELD;
            end
            HELD: begin
                port_full = 1'b1;
                if (inport_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            inport_prev <= 1'b0;
        end else begin
            state       <= state_next;
            inport_prev <= InPortout;
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= 32'd0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                fifo_mem[wr_ptr] <= dev_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            device_data       <= 32'd0;
            Input_port_strobe <= 1'b0;
            delivered_count   <= 8'd0;
        end else begin
            Input_port_strobe <= pop;
            if (pop) begin
                device_data     <= fifo_mem[rd_ptr];
                delivered_count <= delivered_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inport_feeder.sv
// Randomised and directed bench for inport_feeder against a queue-based model.
`default_nettype none

module tb_inport_feeder;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] dev_data;
    logic        dev_valid;
    logic        dev_ready;
    logic        InPortout;
    logic [31:0] device_data;
    logic        Input_port_strobe;
    logic        port_full;
    logic [1:0]  fifo_count;
    logic [7:0]  delivered_count;

    inport_feeder #(.DEPTH(2)) dut (
        .clock             (clock),
        .clear             (clear),
        .dev_data          (dev_data),
        .dev_valid         (dev_valid),
        .dev_ready         (dev_ready),
        .InPortout         (InPortout),
        .device_data       (device_data),
        .Input_port_strobe (Input_port_strobe),
        .port_full         (port_full),
        .fifo_count        (fifo_count),
        .delivered_count   (delivered_count)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: queue of waiting words, plus the age of the word in the port
    // (-1 = port empty, 0 = just loaded, 1 = waiting for the CPU read).
    logic [31:0] m_q[$];
    int          m_age;
    logic [31:0] m_data;
    logic [7:0]  m_deliv;
    bit          m_prev;
    bit          m_last_push;
    int          m_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_age       = -1;
        m_data      = 32'd0;
        m_deliv     = 8'd0;
        m_prev      = 1'b0;
        m_last_push = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit ip);
        bit ready;
        if (!clear) begin
            model_reset();
            return;
        end
        ready = (m_q.size() < 2);
        if (m_age < 0) begin
            if (m_q.size() > 0) begin
                m_data = m_q.pop_front();
                m_age  = 0;
                m_deliv++;
                m_total++;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (ip && !m_prev) begin
            m_age = -1;
        end
        m_last_push = v && ready;
        if (m_last_push) m_q.push_back(d);
        m_prev = ip;
    endtask

    task automatic compare_outputs();
        check("dev_ready",   32'(dev_ready),         32'(m_q.size() < 2));
        check("fifo_count",  32'(fifo_count),        32'(m_q.size()));
        check("port_full",   32'(port_full),         32'(m_age >= 0));
        check("strobe",      32'(Input_port_strobe), 32'(m_age == 0));
        check("device_data", device_data,            m_data);
        check("delivered",   32'(delivered_count),   32'(m_deliv));
    endtask

    // One clock: compare at the falling edge, drive, then advance the model.
    task automatic cycle(input bit v, input logic [31:0] d, input bit ip);
        @(negedge clock);
        compare_outputs();
        dev_valid = v;
        dev_data  = d;
        InPortout = ip;
        @(posedge clock);
        model_edge(v, d, ip);
    endtask

    // Called right after a rising edge; asserts clear between edges.
    task automatic mid_cycle_reset();
        #2 clear = 1'b0;
        #1;
        check("rst_strobe",    32'(Input_port_strobe), 32'd0);
        check("rst_port_full", 32'(port_full),         32'd0);
        check("rst_fifo",      32'(fifo_count),        32'd0);
        check("rst_data",      device_data,            32'd0);
        check("rst_deliv",     32'(delivered_count),   32'd0);
        model_reset();
        cycle(1'b0, 32'd0, 1'b0);
        #2 clear = 1'b1;
    endtask

    initial begin
        logic [31:0] strobed[$];
        int          strobes;
        int          base;
        int          guard;
        bit          dpend;
        bit          ip;
        logic [7:0]  deliv_before;

        clear     = 1'b0;
        dev_valid = 1'b0;
        dev_data  = 32'd0;
        InPortout = 1'b0;
        m_total   = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        compare_outputs();
        clear = 1'b1;

        // Single word through an empty feeder.
        cycle(1'b1, 32'h0000_0036, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        #1;
        check("sw_strobe", 32'(Input_port_strobe), 32'd1);
        check("sw_data",   device_data,            32'h0000_0036);
        check("sw_full",   32'(port_full),         32'd1);
        check("sw_deliv",  32'(delivered_count),   32'd1);
        check("sw_fifo",   32'(fifo_count),        32'd0);
        cycle(1'b0, 32'd0, 1'b0);
        #1;
        check("sw_pulse_end", 32'(Input_port_strobe), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0);

        // Backpressure and ordering.
        cycle(1'b1, 32'hA, 1'b0);
        cycle(1'b1, 32'hB, 1'b0);
        cycle(1'b1, 32'hC, 1'b0);
        cycle(1'b1, 32'hD, 1'b0);
        cycle(1'b1, 32'hD, 1'b0);
        #1;
        check("bp_ready", 32'(dev_ready),  32'd0);
        check("bp_fifo",  32'(fifo_count), 32'd2);
        check("bp_port",  device_data,     32'hA);
        dpend   = 1'b1;
        strobes = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(dpend, 32'hD, (k == 0));
                if (m_last_push) dpend = 1'b0;
                #1;
                if (Input_port_strobe === 1'b1) begin
                    strobes++;
                    strobed.push_back(device_data);
                end
            end
        end
        check("ord_strobes", 32'(strobes), 32'd3);
        if (strobed.size() == 3) begin
            check("ord_0", strobed[0], 32'hB);
            check("ord_1", strobed[1], 32'hC);
            check("ord_2", strobed[2], 32'hD);
        end else begin
            check("ord_size", 32'(strobed.size()), 32'd3);
        end
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0);

        // Held InPortout counts once.
        cycle(1'b1, 32'h11, 1'b0);
        cycle(1'b1, 32'h22, 1'b0);
        cycle(1'b1, 32'h33, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        #1 deliv_before = delivered_count;
        repeat (5) cycle(1'b0, 32'd0, 1'b1);
        repeat (3) cycle(1'b0, 32'd0, 1'b0);
        #1 check("held_once", 32'(delivered_count - deliv_before), 32'd1);

        // Reset in LOAD, then empty FIFO and minimum latency after release.
        cycle(1'b0, 32'd0, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h5, 1'b0);
        cycle(1'b1, 32'h6, 1'b0);
        #1 check("pre_rst_load", 32'(Input_port_strobe), 32'd1);
        mid_cycle_reset();
        repeat (3) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h77, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        #1;
        check("lat_strobe", 32'(Input_port_strobe), 32'd1);
        check("lat_data",   device_data,            32'h77);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
        end

        // Wrap of delivered_count.
        mid_cycle_reset();
        base  = m_total;
        guard = 0;
        ip    = 1'b0;
        while ((m_total - base) < 256 && guard < 4000) begin
            cycle(1'b1, $urandom, ip);
            ip = !ip;
            guard++;
        end
        check("wrap_words", 32'(m_total - base), 32'd256);
        #1 check("wrap_count", 32'(delivered_count), 32'd0);
        repeat (4) cycle(1'b0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
